writeback_select_unit: RTL

//  Parametrised write-back stage for the MIPS datapath. It selects the register-file write

---
 rtl/writeback_select_unit.sv | 79 +++++++
 1 files changed

// File: rtl/writeback_select_unit.sv
// writeback_select_unit: registered write-back mux with a valid handshake and timeout for slow sources
module writeback_select_unit #(
  parameter int DATA_W = 32,
  parameter int N_SRC = 5,
  parameter int SEL_W = 3,
  parameter int PC_SRC = 2,
  parameter int PC_INC = 1,
  parameter logic [N_SRC-1:0] SLOW_MASK = 5'b11000,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_req,
  input  logic [SEL_W-1:0]        wb_sel,
  input  logic [4:0]              wb_addr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [DATA_W-1:0]       pc_current,
  output logic                    stall,
  output logic                    rf_we,
  output logic [4:0]              rf_addr,
  output logic [DATA_W-1:0]       rf_data,
  output logic                    sel_err,
  output logic                    timeout_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] es, es_q, cur;
  logic [4:0] addr_q;
  logic [DATA_W-1:0] pc_q, pc_use, data;
  logic [15:0] cnt;
  logic bad_sel, vld, slow, tmo, commit;
  // pick the active source (live request or the pending one) and decide stall/commit/next state
  always_comb begin
    bad_sel = {1'b0, wb_sel} >= (SEL_W+1)'(N_SRC);
    es = bad_sel ? SEL_W'(N_SRC-1) : wb_sel;
    cur = (state == WAIT) ? es_q : es;
    vld = src_valid[cur];
    slow = SLOW_MASK[cur];
    pc_use = (state == WAIT) ? pc_q : pc_current;
    data = (cur == SEL_W'(PC_SRC)) ? pc_use + DATA_W'(PC_INC) : src_data[int'(cur)*DATA_W +: DATA_W];
    stall = rst_n && ((state == WAIT) ? !vld : (wb_req && slow && !vld));
    tmo = (state == WAIT) && !vld && (cnt == 16'(TIMEOUT));
    commit = (state == WAIT) ? (vld || tmo) : (wb_req && !(slow && !vld));
    state_nx = (state == WAIT) ? (commit ? IDLE : WAIT) : ((wb_req && slow && !vld) ? WAIT : IDLE);
  end
  // state, pending-request capture, wait counter and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      es_q <= '0;
      addr_q <= '0;
      pc_q <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      sel_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      rf_we <= commit;
      sel_err <= (state == IDLE) && wb_req && bad_sel;
      if (commit) begin
        rf_addr <= (state == WAIT) ? addr_q : wb_addr;
        rf_data <= tmo ? '0 : data;
      end
      if (tmo) timeout_err <= 1'b1;
      if (state == IDLE) begin
        es_q <= es;
        addr_q <= wb_addr;
        pc_q <= pc_current;
        cnt <= '0;
      end else if (!vld) begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule
